// File: rtl/trans_ctrl_pkg.sv
// Shared definitions for the transaction-layer control FSM.
// Latency: n/a (constants only).
// Backpressure: n/a.
package trans_ctrl_pkg;

  localparam int ST_W   = 3;
  localparam int HOLD_W = 4;

  localparam logic [ST_W-1:0] ST_RESET  = 3'd0;
  localparam logic [ST_W-1:0] ST_INIT   = 3'd1;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [ST_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [ST_W-1:0] ST_ERROR  = 3'd4;

  // Encodings the FSM is allowed to sit in; anything else is recovered to RESET.
  function automatic logic st_legal(input logic [ST_W-1:0] st);
    return (st <= ST_ERROR);
  endfunction

endpackage

// File: rtl/trans_pause_hyst.sv
// Hysteretic pause register: set on any almost-full, clear on all almost-empty, else hold.
// Latency: 1 cycle from set/clr to pause.
// Backpressure: pause is itself the upstream stop; forced low whenever en is low.
module trans_pause_hyst (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic set,
  input  logic clr,
  output logic pause
);

  logic pause_q;
  logic pause_d;

  // Next pause value: gate dominates, then set beats clear, otherwise hold.
  always_comb begin
    pause_d = pause_q;
    if (!en) begin
      pause_d = 1'b0;
    end else if (set) begin
      pause_d = 1'b1;
    end else if (clr) begin
      pause_d = 1'b0;
    end
  end

  // Pause flop with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
    end
  end

  assign pause = pause_q;

endmodule

// File: rtl/trans_ctrl_fsm.sv
// Transaction-layer control FSM: RESET/INIT/IDLE/ACTIVE/ERROR sequencing, watermark latching, pause.
// Latency: all outputs registered; idle/active/error decoded from next state (valid with the state).
// Backpressure: drives pause to upstream sources; optional active_cycles via TRANS_CTRL_ACTIVE_CNT_EN.
module trans_ctrl_fsm
  import trans_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS = 10,
  parameter int UMBRAL_W  = 3,
  parameter int DEF_ALTO  = 6,
  parameter int DEF_BAJO  = 2,
  parameter int IDLE_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  umbral_alto,
  input  logic [UMBRAL_W-1:0]  umbral_bajo,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_almost_full,
  input  logic [NUM_FIFOS-1:0] fifo_almost_empty,
  output logic [UMBRAL_W-1:0]  interno_alto,
  output logic [UMBRAL_W-1:0]  interno_bajo,
  output logic                 idle,
  output logic                 active,
  output logic                 error,
  output logic                 pause,
  output logic [2:0]           state
`ifdef TRANS_CTRL_ACTIVE_CNT_EN
  ,
  output logic [15:0]          active_cycles
`endif
);

  logic [ST_W-1:0]     state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic [UMBRAL_W-1:0] alto_q, alto_d, bajo_q, bajo_d;
  logic                idle_q, idle_d, active_q, active_d, error_q, error_d;
  logic                all_empty;
  logic                thr_ok;
  logic                stay_active;

  assign all_empty   = &fifo_empty;
  assign thr_ok      = (umbral_bajo < umbral_alto);
  assign hold_inc    = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + 1'b1;
  assign stay_active = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      hold_q   <= '0;
      alto_q   <= UMBRAL_W'(DEF_ALTO);
      bajo_q   <= UMBRAL_W'(DEF_BAJO);
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      idle_q   <= idle_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic; init overrides every legal state except RESET.
  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = thr_ok ? ST_IDLE : ST_ERROR;
      ST_IDLE:   state_d = all_empty ? ST_IDLE : ST_ACTIVE;
      ST_ACTIVE: state_d = (all_empty && (hold_inc >= HOLD_W'(IDLE_HOLD))) ? ST_IDLE : ST_ACTIVE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (init && (state_q != ST_RESET) && st_legal(state_q)) begin
      state_d = ST_INIT;
    end
  end

  // Output/datapath decode from next state: flags, threshold latch, idle-hold counter.
  always_comb begin
    idle_d   = (state_d == ST_IDLE);
    active_d = (state_d == ST_ACTIVE);
    error_d  = (state_d == ST_ERROR);
    alto_d   = alto_q;
    bajo_d   = bajo_q;
    if ((state_q == ST_INIT) && thr_ok) begin
      alto_d = umbral_alto;
      bajo_d = umbral_bajo;
    end
    hold_d = '0;
    if (stay_active && all_empty) begin
      hold_d = hold_inc;
    end
  end

  trans_pause_hyst u_pause (
    .clk   (clk),
    .reset (reset),
    .en    (stay_active),
    .set   (|fifo_almost_full),
    .clr   (&fifo_almost_empty),
    .pause (pause)
  );

`ifdef TRANS_CTRL_ACTIVE_CNT_EN
  logic [15:0] act_cnt_q, act_cnt_d;

  // ACTIVE-cycle counter: cleared entering INIT, saturating, held elsewhere.
  always_comb begin
    act_cnt_d = act_cnt_q;
    if (state_d == ST_INIT) begin
      act_cnt_d = '0;
    end else if ((state_d == ST_ACTIVE) && (act_cnt_q != 16'hFFFF)) begin
      act_cnt_d = act_cnt_q + 16'd1;
    end
  end

  // ACTIVE-cycle counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_cnt_q <= '0;
    end else begin
      act_cnt_q <= act_cnt_d;
    end
  end

  assign active_cycles = act_cnt_q;
`endif

  assign interno_alto = alto_q;
  assign interno_bajo = bajo_q;
  assign idle         = idle_q;
  assign active       = active_q;
  assign error        = error_q;
  assign state        = state_q;

endmodule

// File: tb/tb_trans_ctrl_fsm.sv
// Bench for trans_ctrl_fsm: cycle model compared every negedge plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_trans_ctrl_fsm;

  localparam int IDLE_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [2:0] umbral_alto, umbral_bajo;
  logic [9:0] fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [2:0] interno_alto, interno_bajo;
  logic       idle, active, error, pause;
  logic [2:0] state;
`ifdef TRANS_CTRL_ACTIVE_CNT_EN
  logic [15:0] active_cycles;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // model state: spec encodings 0..4
  int m_st = 0, m_alto = 6, m_bajo = 2, m_hold = 0, m_pause = 0, m_cnt = 0;

  always #5 clk = ~clk;

  trans_ctrl_fsm dut (
    .clk               (clk),
    .reset             (reset),
    .init              (init),
    .umbral_alto       (umbral_alto),
    .umbral_bajo       (umbral_bajo),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .interno_alto      (interno_alto),
    .interno_bajo      (interno_bajo),
    .idle              (idle),
    .active            (active),
    .error             (error),
    .pause             (pause),
    .state             (state)
`ifdef TRANS_CTRL_ACTIVE_CNT_EN
    ,
    .active_cycles     (active_cycles)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one step per rising edge, from the rules in plain terms.
  always @(posedge clk) begin : model
    int nxt;
    if (!reset) begin
      m_st = 0; m_alto = 6; m_bajo = 2; m_hold = 0; m_pause = 0; m_cnt = 0;
    end else begin
      nxt = m_st;
      case (m_st)
        0: nxt = 1;
        1: begin
          if (int'(umbral_bajo) < int'(umbral_alto)) begin
            m_alto = int'(umbral_alto);
            m_bajo = int'(umbral_bajo);
            nxt = 2;
          end else begin
            nxt = 4;
          end
        end
        2: if (fifo_empty != 10'h3FF) nxt = 3;
        3: begin
          if (fifo_empty == 10'h3FF) begin
            if (m_hold < 15) m_hold = m_hold + 1;
            if (m_hold >= IDLE_HOLD) nxt = 2;
          end else begin
            m_hold = 0;
          end
        end
        4: nxt = 4;
        default: nxt = 0;
      endcase
      if (init && m_st != 0) nxt = 1;
      if (m_st == 3 && nxt == 3) begin
        if (fifo_almost_full != 0) m_pause = 1;
        else if (fifo_almost_empty == 10'h3FF) m_pause = 0;
      end else begin
        m_pause = 0;
      end
      if (nxt != 3) m_hold = 0;
      if (nxt == 1) m_cnt = 0;
      else if (nxt == 3 && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_st = nxt;
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_state",  int'(state),        m_st);
      chk("cyc_idle",   int'(idle),         int'(m_st == 2));
      chk("cyc_active", int'(active),       int'(m_st == 3));
      chk("cyc_error",  int'(error),        int'(m_st == 4));
      chk("cyc_pause",  int'(pause),        m_pause);
      chk("cyc_alto",   int'(interno_alto), m_alto);
      chk("cyc_bajo",   int'(interno_bajo), m_bajo);
`ifdef TRANS_CTRL_ACTIVE_CNT_EN
      chk("cyc_cnt",    int'(active_cycles), m_cnt);
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Hand-computed expectations; also pins the model's state.
  task automatic lit(input string tag, input int st, input int idl, input int act,
                     input int err, input int pau, input int alto, input int bajo);
    chk({tag, "_state"},  int'(state),        st);
    chk({tag, "_mstate"}, m_st,               st);
    chk({tag, "_idle"},   int'(idle),         idl);
    chk({tag, "_active"}, int'(active),       act);
    chk({tag, "_error"},  int'(error),        err);
    chk({tag, "_pause"},  int'(pause),        pau);
    chk({tag, "_alto"},   int'(interno_alto), alto);
    chk({tag, "_bajo"},   int'(interno_bajo), bajo);
  endtask

  initial begin
    reset = 1'b0; init = 1'b0;
    umbral_alto = 3'd5; umbral_bajo = 3'd1;
    fifo_empty = 10'h3FF; fifo_almost_full = '0; fifo_almost_empty = '0;
    step(2);
    cmp_en = 1;
    lit("rst", 0, 0, 0, 0, 0, 6, 2);

    // reset release: INIT then IDLE with 5/1 latched
    reset = 1'b1;
    step(); lit("rel_init", 1, 0, 0, 0, 0, 6, 2);
    step(); lit("rel_idle", 2, 1, 0, 0, 0, 5, 1);

    // invalid thresholds go to ERROR keeping defaults
    reset = 1'b0; umbral_alto = 3'd2; umbral_bajo = 3'd3;
    step();
    reset = 1'b1;
    step(); step(); lit("bad_thr", 4, 0, 0, 1, 0, 6, 2);
    step(); lit("err_hold", 4, 0, 0, 1, 0, 6, 2);
    umbral_alto = 3'd6; umbral_bajo = 3'd2; init = 1'b1;
    step(); lit("reinit", 1, 0, 0, 0, 0, 6, 2);
    init = 1'b0;
    step(); lit("reinit_idle", 2, 1, 0, 0, 0, 6, 2);

    // idle-entry hold filter
    fifo_empty = 10'h3FE;
    step(); lit("go_act", 3, 0, 1, 0, 0, 6, 2);
    fifo_empty = 10'h3FF;
    step(); lit("hold1", 3, 0, 1, 0, 0, 6, 2);
    step(); lit("hold2_idle", 2, 1, 0, 0, 0, 6, 2);
    fifo_empty = 10'h3FE; step();
    fifo_empty = 10'h3FF; step();
    fifo_empty = 10'h3FE; step();
    fifo_empty = 10'h3FF; step(); lit("restart1", 3, 0, 1, 0, 0, 6, 2);
    step(); lit("restart_idle", 2, 1, 0, 0, 0, 6, 2);

    // pause hysteresis in ACTIVE
    fifo_empty = 10'h3FE; step();
    fifo_almost_full = 10'h010;
    step(); lit("pause_set", 3, 0, 1, 0, 1, 6, 2);
    fifo_almost_full = '0; fifo_almost_empty = 10'h1FF;
    step(); lit("pause_hold", 3, 0, 1, 0, 1, 6, 2);
    fifo_almost_empty = 10'h3FF;
    step(); lit("pause_clr", 3, 0, 1, 0, 0, 6, 2);
    fifo_almost_full = 10'h010;
    step(); lit("pause_both", 3, 0, 1, 0, 1, 6, 2);

    // init mid-ACTIVE with pause high
    umbral_alto = 3'd7; umbral_bajo = 3'd3; init = 1'b1;
    fifo_almost_full = '0; fifo_almost_empty = '0;
    step(); lit("init_act", 1, 0, 0, 0, 0, 6, 2);
    init = 1'b0; fifo_empty = 10'h3FF;
    step(); lit("init_idle", 2, 1, 0, 0, 0, 7, 3);
    fifo_almost_full = 10'h010;
    step(); lit("idle_nopause", 2, 1, 0, 0, 0, 7, 3);

    // reset mid-ACTIVE
    fifo_empty = 10'h3FE; step(); step();
    lit("pre_rst", 3, 0, 1, 0, 1, 7, 3);
    reset = 1'b0;
    step(); lit("rst_act", 0, 0, 0, 0, 0, 6, 2);
    reset = 1'b1; fifo_almost_full = '0; fifo_empty = 10'h3FF;
    step(2); lit("rst_rel", 2, 1, 0, 0, 0, 7, 3);

`ifdef TRANS_CTRL_ACTIVE_CNT_EN
    fifo_empty = 10'h3FE;
    step(20); chk("cnt20", int'(active_cycles), 20);
    fifo_empty = 10'h3FF;
    step(2); chk("cnt_idle_state", int'(state), 2);
    chk("cnt_idle", int'(active_cycles), 21);
    step(3); chk("cnt_held", int'(active_cycles), 21);
    init = 1'b1;
    step(); chk("cnt_init", int'(active_cycles), 0);
    init = 1'b0;
    step();
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
